score_timer: RTL and testbench

//  Run/pause/stop controller and tick prescaler for the survival-time score display.
//  It emits a 1-cycle count pulse at a fixed rate to the least-significant digit counter.
//  The digit chain cascades via its overflow outputs.

---
 rtl/score_timer.sv | 134 +++++++++++++
 tb/tb_score_timer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/score_timer.sv
// Run/pause/stop controller and count-pulse prescaler for the survival-time score display.
// Emits count and digit_clear pulses to the digit chain, plus a blink flag while paused.
module score_timer #(
    parameter int unsigned CLK_DIV = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       game_over,
    output logic       count,
    output logic       digit_clear,
    output logic       running,
    output logic       blank,
    output logic [1:0] state
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] TERM = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [PW-1:0]   blink_q, blink_d;
    logic            start_q, start_d;
    logic            pause_q, pause_d;
    logic            count_q, count_d;
    logic            clear_q, clear_d;
    logic            running_q, running_d;
    logic            blank_q, blank_d;
    logic            start_rise, pause_rise;

    // Button history resets high so a button held through reset needs a fresh press.
    assign start_rise = start_btn & ~start_q;
    assign pause_rise = pause_btn & ~pause_q;

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        blink_d   = blink_q;
        blank_d   = blank_q;
        count_d   = 1'b0;
        clear_d   = 1'b0;
        start_d   = start_btn;
        pause_d   = pause_btn;

        unique case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d = S_RUN;
                    clear_d = 1'b1;
                    pre_d   = '0;
                end
            end
            S_RUN: begin
                // Death beats pause and the terminal count; transition edges hold the prescaler.
                if (game_over) begin
                    state_d = S_DONE;
                end else if (pause_rise) begin
                    state_d = S_PAUSE;
                    blank_d = 1'b1;
                    blink_d = '0;
                end else if (pre_q == TERM) begin
                    pre_d   = '0;
                    count_d = 1'b1;
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            S_PAUSE: begin
                if (game_over) begin
                    state_d = S_DONE;
                    blank_d = 1'b0;
                end else if (pause_rise) begin
                    state_d = S_RUN;
                    blank_d = 1'b0;
                    blink_d = '0;
                end else if (blink_q == TERM) begin
                    blink_d = '0;
                    blank_d = ~blank_q;
                end else begin
                    blink_d = blink_q + PW'(1);
                end
            end
            S_DONE: begin
                if (start_rise && !game_over) begin
                    state_d = S_RUN;
                    clear_d = 1'b1;
                    pre_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pre_q     <= '0;
            blink_q   <= '0;
            start_q   <= 1'b1;
            pause_q   <= 1'b1;
            count_q   <= 1'b0;
            clear_q   <= 1'b0;
            running_q <= 1'b0;
            blank_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            blink_q   <= blink_d;
            start_q   <= start_d;
            pause_q   <= pause_d;
            count_q   <= count_d;
            clear_q   <= clear_d;
            running_q <= running_d;
            blank_q   <= blank_d;
        end
    end

    assign count       = count_q;
    assign digit_clear = clear_q;
    assign running     = running_q;
    assign blank       = blank_q;
    assign state       = 2'(state_q);

endmodule

// File: tb/tb_score_timer.sv
// Bench for score_timer: cycle model feeds an expected-output queue, plus directed scenario checks.
module tb_score_timer;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       game_over = 1'b0;
    logic       count, digit_clear, running, blank;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0] exp_q[$];

    score_timer #(.CLK_DIV(DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_btn   (start_btn),
        .pause_btn   (pause_btn),
        .game_over   (game_over),
        .count       (count),
        .digit_clear (digit_clear),
        .running     (running),
        .blank       (blank),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model: advances on each edge from the sampled inputs, queues the expected outputs.
    int   m_state, m_pre, m_blink;
    logic m_count, m_clear, m_running, m_blank, m_sq, m_pq;

    always @(posedge clk or posedge reset) begin
        logic srise, prise;
        if (reset) begin
            m_state = 0; m_pre = 0; m_blink = 0;
            m_count = 0; m_clear = 0; m_running = 0; m_blank = 0;
            m_sq = 1; m_pq = 1;
            exp_q.delete();
        end else begin
            srise = start_btn & ~m_sq;
            prise = pause_btn & ~m_pq;
            m_sq = start_btn;
            m_pq = pause_btn;
            m_count = 0;
            m_clear = 0;
            case (m_state)
                0: if (srise) begin m_state = 1; m_clear = 1; m_pre = 0; end
                1: begin
                    if (game_over) m_state = 3;
                    else if (prise) begin m_state = 2; m_blank = 1; m_blink = 0; end
                    else if (m_pre == DIV - 1) begin m_pre = 0; m_count = 1; end
                    else m_pre++;
                end
                2: begin
                    if (game_over) begin m_state = 3; m_blank = 0; end
                    else if (prise) begin m_state = 1; m_blank = 0; m_blink = 0; end
                    else if (m_blink == DIV - 1) begin m_blink = 0; m_blank = ~m_blank; end
                    else m_blink++;
                end
                default: if (srise && !game_over) begin m_state = 1; m_clear = 1; m_pre = 0; end
            endcase
            m_running = (m_state == 1);
            exp_q.push_back({2'(m_state), m_count, m_clear, m_running, m_blank});
        end
    end

    always @(negedge clk) begin
        logic [5:0] e;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("model_outs", {state, count, digit_clear, running, blank}, e);
            if (count && digit_clear) chk("count_clear_overlap", 1, 0);
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_clear"}, digit_clear, 0);
        chk({tag, "_running"}, running, 0);
        chk({tag, "_blank"}, blank, 0);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);

        // Start: clear pulse, then count on RUN edges 4, 8 and 12.
        start_btn = 1'b1;
        @(negedge clk);
        chk("start_clear", digit_clear, 1);
        chk("start_running", running, 1);
        chk("start_state", state, 1);
        chk("start_count", count, 0);
        start_btn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat (3) @(negedge clk);
            chk("count_before", count, 0);
            @(negedge clk);
            chk("count_pulse", count, 1);
        end

        // Pause with prescaler at 2, watch blink, resume.
        repeat (2) @(negedge clk);
        pause_btn = 1'b1;
        @(negedge clk);
        chk("pause_state", state, 2);
        chk("pause_blank_first", blank, 1);
        chk("pause_running", running, 0);
        pause_btn = 1'b0;
        repeat (3) @(negedge clk);
        chk("blank_hold", blank, 1);
        chk("pause_count", count, 0);
        @(negedge clk);
        chk("blank_toggle0", blank, 0);
        repeat (4) @(negedge clk);
        chk("blank_toggle1", blank, 1);
        pause_btn = 1'b1;
        @(negedge clk);
        chk("resume_state", state, 1);
        chk("resume_blank", blank, 0);
        pause_btn = 1'b0;
        @(negedge clk);
        chk("resume_count_early", count, 0);
        @(negedge clk);
        chk("resume_count", count, 1);

        // game_over exactly when the terminal count would fire.
        repeat (3) @(negedge clk);
        game_over = 1'b1;
        @(negedge clk);
        chk("over_state", state, 3);
        chk("over_count", count, 0);
        chk("over_running", running, 0);

        // Start while still dead is ignored; once alive it restarts.
        start_btn = 1'b1;
        repeat (2) @(negedge clk);
        chk("dead_start_state", state, 3);
        chk("dead_start_clear", digit_clear, 0);
        start_btn = 1'b0;
        game_over = 1'b0;
        @(negedge clk);
        start_btn = 1'b1;
        @(negedge clk);
        chk("restart_state", state, 1);
        chk("restart_clear", digit_clear, 1);
        start_btn = 1'b0;
        repeat (5) @(negedge clk);

        // Asynchronous reset mid-RUN, start held through release.
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        start_btn = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_start_state", state, 0);
        start_btn = 1'b0;
        @(negedge clk);
        start_btn = 1'b1;
        @(negedge clk);
        chk("fresh_start_state", state, 1);
        chk("fresh_start_clear", digit_clear, 1);
        start_btn = 1'b0;
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
